// File: rtl/gabor_window_5x5.sv
// Raster-stream 5x5 window generator feeding the Gabor convolution blocks.
// Optional macro GABOR_WIN_COORD_EN adds registered window-centre coordinates.
module gabor_window_5x5 #(
  parameter int PIX_INT_W = 9,
  parameter int PIX_DEC_W = 0,
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  localparam int PW = PIX_INT_W + PIX_DEC_W,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic signed [PW-1:0] in_pixel,
  output logic                 out_valid,
`ifdef GABOR_WIN_COORD_EN
  output logic        [RW-1:0] out_row,
  output logic        [CW-1:0] out_col,
`endif
  output logic signed [PW-1:0] pixel1,
  output logic signed [PW-1:0] pixel2,
  output logic signed [PW-1:0] pixel3,
  output logic signed [PW-1:0] pixel4,
  output logic signed [PW-1:0] pixel5,
  output logic signed [PW-1:0] pixel6,
  output logic signed [PW-1:0] pixel7,
  output logic signed [PW-1:0] pixel8,
  output logic signed [PW-1:0] pixel9,
  output logic signed [PW-1:0] pixel10,
  output logic signed [PW-1:0] pixel11,
  output logic signed [PW-1:0] pixel12,
  output logic signed [PW-1:0] pixel13,
  output logic signed [PW-1:0] pixel14,
  output logic signed [PW-1:0] pixel15,
  output logic signed [PW-1:0] pixel16,
  output logic signed [PW-1:0] pixel17,
  output logic signed [PW-1:0] pixel18,
  output logic signed [PW-1:0] pixel19,
  output logic signed [PW-1:0] pixel20,
  output logic signed [PW-1:0] pixel21,
  output logic signed [PW-1:0] pixel22,
  output logic signed [PW-1:0] pixel23,
  output logic signed [PW-1:0] pixel24,
  output logic signed [PW-1:0] pixel25
);

  logic [CW-1:0] col_q, col_d, pos_col;
  logic [RW-1:0] row_q, row_d, pos_row;
  logic          out_valid_q, out_valid_d;
  logic signed [PW-1:0] win_q [25];
  logic signed [PW-1:0] win_d [25];
  logic signed [PW-1:0] col_tap [5];
  logic signed [PW-1:0] lb_mem [4][IMG_W];

  // SOF overrides the counters so the accepted pixel lands at (0,0).
  always_comb begin
    pos_col = in_sof ? '0 : col_q;
    pos_row = in_sof ? '0 : row_q;
    col_tap[0] = lb_mem[3][pos_col];
    col_tap[1] = lb_mem[2][pos_col];
    col_tap[2] = lb_mem[1][pos_col];
    col_tap[3] = lb_mem[0][pos_col];
    col_tap[4] = in_pixel;
  end

  // NOTE: every variable gets a default before the conditional updates, so no latch is inferred.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = 1'b0;
    win_d       = win_q;
    if (in_valid) begin
      if (pos_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (pos_row == RW'(IMG_H - 1)) ? '0 : pos_row + RW'(1);
      end else begin
        col_d = pos_col + CW'(1);
        row_d = pos_row;
      end
      out_valid_d = (pos_row >= RW'(4)) && (pos_col >= CW'(4));
      for (int k = 0; k < 5; k++) begin
        for (int j = 0; j < 4; j++) win_d[5*k+j] = win_q[5*k+j+1];
        win_d[5*k+4] = col_tap[k];
      end
    end
  end

  // NOTE: line memories carry no reset; stale lines are never exposed because valid windows need row>=4.
  always_ff @(posedge clk) begin
    if (in_valid && !rst) begin
      // NOTE: non-blocking writes read the old LB(k-1) value, giving the read-before-write cascade.
      lb_mem[0][pos_col] <= in_pixel;
      for (int k = 1; k < 4; k++) lb_mem[k][pos_col] <= lb_mem[k-1][pos_col];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 25; i++) win_q[i] <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      win_q       <= win_d;
    end
  end

`ifdef GABOR_WIN_COORD_EN
  logic [RW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;

  always_comb begin
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    if (out_valid_d) begin
      out_row_d = pos_row - RW'(2);
      out_col_d = pos_col - CW'(2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_row_q <= '0;
      out_col_q <= '0;
    end else begin
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
    end
  end

  assign out_row = out_row_q;
  assign out_col = out_col_q;
`endif

  assign out_valid = out_valid_q;
  assign pixel1  = win_q[0];
  assign pixel2  = win_q[1];
  assign pixel3  = win_q[2];
  assign pixel4  = win_q[3];
  assign pixel5  = win_q[4];
  assign pixel6  = win_q[5];
  assign pixel7  = win_q[6];
  assign pixel8  = win_q[7];
  assign pixel9  = win_q[8];
  assign pixel10 = win_q[9];
  assign pixel11 = win_q[10];
  assign pixel12 = win_q[11];
  assign pixel13 = win_q[12];
  assign pixel14 = win_q[13];
  assign pixel15 = win_q[14];
  assign pixel16 = win_q[15];
  assign pixel17 = win_q[16];
  assign pixel18 = win_q[17];
  assign pixel19 = win_q[18];
  assign pixel20 = win_q[19];
  assign pixel21 = win_q[20];
  assign pixel22 = win_q[21];
  assign pixel23 = win_q[22];
  assign pixel24 = win_q[23];
  assign pixel25 = win_q[24];

endmodule

// File: tb/tb_gabor_window_5x5.sv
// Bench for gabor_window_5x5 on an 8x6 image: directed frame scenarios plus random traffic vs an image-array model.
module tb_gabor_window_5x5;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 9;

  logic clk = 1'b0;
  logic rst, in_valid, in_sof;
  logic signed [PW-1:0] in_pixel;
  logic out_valid;
  logic signed [PW-1:0] pix [25];
`ifdef GABOR_WIN_COORD_EN
  logic [2:0] out_row, out_col;
`endif

  always #5 clk = ~clk;

  gabor_window_5x5 #(.PIX_INT_W(9), .PIX_DEC_W(0), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .out_valid(out_valid),
`ifdef GABOR_WIN_COORD_EN
    .out_row(out_row), .out_col(out_col),
`endif
    .pixel1(pix[0]),   .pixel2(pix[1]),   .pixel3(pix[2]),   .pixel4(pix[3]),   .pixel5(pix[4]),
    .pixel6(pix[5]),   .pixel7(pix[6]),   .pixel8(pix[7]),   .pixel9(pix[8]),   .pixel10(pix[9]),
    .pixel11(pix[10]), .pixel12(pix[11]), .pixel13(pix[12]), .pixel14(pix[13]), .pixel15(pix[14]),
    .pixel16(pix[15]), .pixel17(pix[16]), .pixel18(pix[17]), .pixel19(pix[18]), .pixel20(pix[19]),
    .pixel21(pix[20]), .pixel22(pix[21]), .pixel23(pix[22]), .pixel24(pix[23]), .pixel25(pix[24])
  );

  typedef struct {
    int p1, p13, p25, orow, ocol;
  } pulse_t;
  pulse_t ramp_tbl[8];

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: the whole image as seen so far, indexed by (row, col).
  logic signed [PW-1:0] img [H][W];
  int m_row, m_col;
  logic mdl_valid;
  logic signed [PW-1:0] mdl_win [25];
  int mdl_r, mdl_c;

  int p1_log[$], p13_log[$], p25_log[$], row_log[$], col_log[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    p1_log.delete(); p13_log.delete(); p25_log.delete(); row_log.delete(); col_log.delete();
  endtask

  task automatic step(input logic v, input logic s, input logic signed [PW-1:0] p);
    int r, c;
    in_valid = v; in_sof = s; in_pixel = p;
    mdl_valid = 1'b0;
    if (v) begin
      r = s ? 0 : m_row;
      c = s ? 0 : m_col;
      img[r][c] = p;
      if (r >= 4 && c >= 4) begin
        mdl_valid = 1'b1;
        for (int k = 0; k < 5; k++)
          for (int j = 0; j < 5; j++) mdl_win[5*k+j] = img[r-4+k][c-4+j];
        mdl_r = r - 2;
        mdl_c = c - 2;
      end
      m_col = (c == W-1) ? 0 : c + 1;
      m_row = (c == W-1) ? ((r == H-1) ? 0 : r + 1) : r;
    end
    @(posedge clk); #1;
    check("out_valid", int'(out_valid), int'(mdl_valid));
    if (mdl_valid && out_valid) begin
      for (int i = 0; i < 25; i++) check($sformatf("pixel%0d", i+1), int'(pix[i]), int'(mdl_win[i]));
`ifdef GABOR_WIN_COORD_EN
      check("out_row", int'(out_row), mdl_r);
      check("out_col", int'(out_col), mdl_c);
`endif
    end
    if (out_valid) begin
      p1_log.push_back(int'(pix[0]));
      p13_log.push_back(int'(pix[12]));
      p25_log.push_back(int'(pix[24]));
`ifdef GABOR_WIN_COORD_EN
      row_log.push_back(int'(out_row));
      col_log.push_back(int'(out_col));
`endif
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_sof = 1'b0; in_pixel = PW'($urandom);
    @(posedge clk); #1;
    check("rst out_valid", int'(out_valid), 0);
    for (int i = 0; i < 25; i++) check($sformatf("rst pixel%0d", i+1), int'(pix[i]), 0);
`ifdef GABOR_WIN_COORD_EN
    check("rst out_row", int'(out_row), 0);
    check("rst out_col", int'(out_col), 0);
`endif
    m_row = 0; m_col = 0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit gap, input bit with_sof);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, with_sof && r == 0 && c == 0, PW'(base + r*W + c));
        if (gap) step(1'b0, 1'b0, PW'($urandom));
      end
  endtask

  task automatic check_ramp(input string tag);
    check({tag, " pulses"}, p1_log.size(), 8);
    for (int i = 0; i < 8 && i < p1_log.size(); i++) begin
      check($sformatf("%s p1[%0d]", tag, i),  p1_log[i],  ramp_tbl[i].p1);
      check($sformatf("%s p13[%0d]", tag, i), p13_log[i], ramp_tbl[i].p13);
      check($sformatf("%s p25[%0d]", tag, i), p25_log[i], ramp_tbl[i].p25);
`ifdef GABOR_WIN_COORD_EN
      check($sformatf("%s row[%0d]", tag, i), row_log[i], ramp_tbl[i].orow);
      check($sformatf("%s col[%0d]", tag, i), col_log[i], ramp_tbl[i].ocol);
`endif
    end
  endtask

  initial begin
    ramp_tbl[0] = '{0, 18, 36, 2, 2};
    ramp_tbl[1] = '{1, 19, 37, 2, 3};
    ramp_tbl[2] = '{2, 20, 38, 2, 4};
    ramp_tbl[3] = '{3, 21, 39, 2, 5};
    ramp_tbl[4] = '{8, 26, 44, 3, 2};
    ramp_tbl[5] = '{9, 27, 45, 3, 3};
    ramp_tbl[6] = '{10, 28, 46, 3, 4};
    ramp_tbl[7] = '{11, 29, 47, 3, 5};

    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    m_row = 0; m_col = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = '0;
    @(negedge clk);
    do_reset();

    clear_logs();
    send_frame(0, 1'b0, 1'b1);
    check_ramp("ramp");

    clear_logs();
    send_frame(0, 1'b1, 1'b1);
    check_ramp("gapped");

    clear_logs();
    for (int i = 0; i < 20; i++) step(1'b1, i == 0, PW'(i));
    send_frame(100, 1'b0, 1'b1);
    check("midsof pulses", p1_log.size(), 8);
    if (p1_log.size() > 0) begin
      check("midsof first p1", p1_log[0], 100);
      check("midsof first p25", p25_log[0], 136);
    end

    clear_logs();
    send_frame(0, 1'b0, 1'b1);
    send_frame(200, 1'b0, 1'b1);
    check("b2b pulses", p1_log.size(), 16);
    if (p1_log.size() > 8) check("b2b frame2 p1", p1_log[8], 200);

    for (int i = 0; i < 4*W + 6; i++) step(1'b1, i == 0, PW'(i));
    do_reset();
    clear_logs();
    send_frame(0, 1'b0, 1'b0);
    check_ramp("post-reset");

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(1'b1 && ($urandom_range(0, 9) < 7), $urandom_range(0, 199) == 0, PW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
